// File: rtl/pipelined_subs_pkg.sv
// rtl/pipelined_subs_pkg.sv - shared constants and offset helper for the adds/subs pipeline pair
package pipelined_subs_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 2;
    localparam int DEFAULT_STEP   = 1;

    // Total amount a word moves through a pipe: stages*step, truncated to width bits.
    function automatic logic [63:0] total_offset(input int width, input int stages, input int step);
        logic [63:0] prod;
        logic [63:0] mask;
        prod = 64'(stages) * 64'(step);
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return prod & mask;
    endfunction

endpackage

// File: rtl/pipelined_subs_if.sv
// rtl/pipelined_subs_if.sv - valid/ready stream bundle for pipelined_subs
interface pipelined_subs_if
    import pipelined_subs_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [WIDTH-1:0] out_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/pipelined_sub_stage.sv
// rtl/pipelined_sub_stage.sv - one enable-gated register stage that subtracts STEP on load
module pipelined_sub_stage
    import pipelined_subs_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Data loads even for bubbles; the top masks it at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (en) begin
            valid <= prev_valid;
            data  <= prev_data - STEP_W;
        end
    end
endmodule

// File: rtl/pipelined_subs.sv
// rtl/pipelined_subs.sv - STAGES-deep subtract pipeline with global stall and delivered-word counter
module pipelined_subs
    import pipelined_subs_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES,
    parameter int STEP   = DEFAULT_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_subs_if.slave      bus
);
    logic [STAGES-1:0] valid_s;
    logic [WIDTH-1:0]  data_s [STAGES];
    logic              advance;
    logic [WIDTH-1:0]  count;

    // Whole pipe stalls only when the last slot holds a word the sink refuses.
    assign advance      = !(valid_s[STAGES-1] && !bus.out_ready);
    assign bus.in_ready = advance;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            pipelined_sub_stage #(.WIDTH(WIDTH), .STEP(STEP)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .en         (advance),
                .prev_valid (bus.in_valid),
                .prev_data  (bus.in_data),
                .valid      (valid_s[s]),
                .data       (data_s[s])
            );
        end else begin : g_next
            pipelined_sub_stage #(.WIDTH(WIDTH), .STEP(STEP)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .en         (advance),
                .prev_valid (valid_s[s-1]),
                .prev_data  (data_s[s-1]),
                .valid      (valid_s[s]),
                .data       (data_s[s])
            );
        end
    end

    assign bus.out_valid = valid_s[STAGES-1];
    assign bus.out_data  = valid_s[STAGES-1] ? data_s[STAGES-1] : '0;
    assign bus.out_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (valid_s[STAGES-1] && bus.out_ready) begin
            count <= count + WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_pipelined_subs.sv
// tb/tb_pipelined_subs.sv - randomized and directed checks of pipelined_subs against a queue model
module tb_pipelined_subs;
    import pipelined_subs_pkg::*;

    localparam int W  = 16;
    localparam int ST = 2;
    localparam int SP = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_subs_if #(.WIDTH(W)) bus ();

    pipelined_subs #(.WIDTH(W), .STAGES(ST), .STEP(SP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] model_count;
    logic         last_accept;

    function automatic logic [W-1:0] sub_model(input logic [W-1:0] x);
        return W'(int'(x) - ST * SP);
    endfunction

    function automatic logic [W-1:0] adds_model(input logic [W-1:0] x);
        return W'(int'(x) + ST * SP);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    // One clock: check combinational outputs before the edge, update the model at the edge,
    // then check registered outputs after it.
    task automatic step();
        logic fire_in, fire_out, stall;
        logic [W-1:0] stall_data;
        #1;
        fire_in    = bus.in_valid && bus.in_ready;
        fire_out   = bus.out_valid && bus.out_ready;
        stall      = bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
        check("in_ready", 32'(bus.in_ready), 32'(!stall));
        if (!bus.out_valid) check("idle_data", 32'(bus.out_data), 32'd0);
        if (fire_out) begin
            if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        end
        @(posedge clk);
        if (fire_out && exp_q.size() != 0) void'(exp_q.pop_front());
        if (fire_out) model_count = model_count + W'(1);
        if (fire_in) exp_q.push_back(sub_model(bus.in_data));
        last_accept = fire_in;
        #1;
        check("out_count", 32'(bus.out_count), 32'(model_count));
        if (stall) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", 32'(bus.out_data), 32'(stall_data));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_count = '0;
        last_accept = 1'b0;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_count", 32'(bus.out_count), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        model_count   = '0;
        last_accept   = 1'b0;
        do_reset();

        // Single word, latency of STAGES edges
        drive(1'b1, 16'd12); step();
        drive(1'b0, 16'd0);  step();
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_data", 32'(bus.out_data), 32'd10);
        step();
        check("count_one", 32'(bus.out_count), 32'd1);

        // Back-to-back streaming
        do_reset();
        drive(1'b1, 16'd12); step();
        drive(1'b1, 16'd17); step();
        check("stream0", 32'(bus.out_data), 32'd10);
        drive(1'b1, 16'd20); step();
        check("stream1", 32'(bus.out_data), 32'd15);
        drive(1'b0, 16'd0);  step();
        check("stream2", 32'(bus.out_data), 32'd18);
        step();
        check("stream_cnt", 32'(bus.out_count), 32'd3);

        // Bubble is masked
        drive(1'b0, 16'd18); step(); step();
        check("bubble_valid", 32'(bus.out_valid), 32'd0);
        check("bubble_data", 32'(bus.out_data), 32'd0);
        check("bubble_cnt", 32'(bus.out_count), 32'd3);

        // Backpressure
        drive(1'b1, 16'd12); step();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'd17); step();
        drive(1'b1, 16'd20);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold", 32'(bus.out_data), 32'd10);
            check("bp_cnt", 32'(bus.out_count), 32'd3);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_rel0", 32'(bus.out_data), 32'd15);
        drive(1'b0, 16'd0);
        step(); step(); step();
        check("bp_cnt_end", 32'(bus.out_count), 32'd6);

        // Data wrap below zero
        drive(1'b1, 16'd1); step();
        drive(1'b1, 16'd0); step();
        check("wrap_ffff", 32'(bus.out_data), 32'h0000_ffff);
        drive(1'b0, 16'd0); step();
        check("wrap_fffe", 32'(bus.out_data), 32'h0000_fffe);
        step();

        // Reset with two words in flight, then a fresh word
        drive(1'b1, 16'd5); step();
        drive(1'b1, 16'd6); step();
        do_reset();
        drive(1'b1, 16'd30); step();
        drive(1'b0, 16'd0);  step();
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data", 32'(bus.out_data), 32'd28);
        step();

        // Loopback through a behavioural pipelined_adds
        drive(1'b1, adds_model(16'd10)); step();
        drive(1'b0, 16'd0); step();
        check("loop10", 32'(bus.out_data), 32'd10);
        step();
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] x;
            x = W'($urandom);
            drive(1'b1, adds_model(x)); step();
            drive(1'b0, 16'd0); step();
            check("loop_rand", 32'(bus.out_data), 32'(x));
        end
        step();

        // Random traffic with random backpressure; upstream holds words until accepted
        for (int i = 0; i < 3000; i++) begin
            if (!(bus.in_valid && !last_accept)) drive($urandom_range(0, 3) != 0, W'($urandom));
            bus.out_ready = $urandom_range(0, 3) != 0;
            step();
        end

        // Drain and confirm nothing was lost
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && bus.in_valid && !last_accept; i++) step();
        drive(1'b0, 16'd0);
        for (int i = 0; i < ST + 2; i++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Counter wrap
        bus.out_ready = 1'b1;
        for (int i = 0; i < 70000 && model_count != 16'hffff; i++) begin
            drive(1'b1, W'($urandom));
            step();
        end
        check("cnt_max", 32'(bus.out_count), 32'h0000_ffff);
        drive(1'b1, W'($urandom)); step();
        check("cnt_wrap", 32'(bus.out_count), 32'd0);
        drive(1'b0, 16'd0);
        for (int i = 0; i < ST + 1; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
